// File: rtl/seg_pkg.sv
`timescale 1ns/1ps
// Shared types and segment encoding for the 7-segment display driver.
//  - SEG_BLANK / SEG_MINUS active-low segment patterns
//  - digit_t: nibble plus blank/minus flags held per display digit
//  - state_e: driver FSM states
package seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;

   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_e;

   typedef struct packed {
      logic       blank;
      logic       minus;
      logic [3:0] nib;
   } digit_t;

   localparam digit_t DIGIT_BLANK = '{blank: 1'b1, minus: 1'b0, nib: 4'h0};
   localparam digit_t DIGIT_MINUS = '{blank: 1'b0, minus: 1'b1, nib: 4'h0};
   localparam digit_t DIGIT_ZERO  = '{blank: 1'b0, minus: 1'b0, nib: 4'h0};

   // Active-low {g..a} pattern for a hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   function automatic logic [6:0] digit_to_seg(input digit_t d);
      if (d.blank)      return SEG_BLANK;
      else if (d.minus) return SEG_MINUS;
      else              return hex_to_seg(d.nib);
   endfunction

   function automatic digit_t make_digit(input logic [3:0] nib, input logic blank);
      digit_t d;
      d.blank = blank;
      d.minus = 1'b0;
      d.nib   = nib;
      return d;
   endfunction

endpackage

// File: rtl/bin_to_bcd.sv
`timescale 1ns/1ps
// Sequential 8-bit double-dabble converter, one shift per cycle.
//  clock, reset_n      : clock, async active-low reset
//  start_i, bin_i      : load a new binary value (ignored state is overwritten)
//  done_c              : high in the cycle whose closing edge performs the 8th shift
//  hundreds_o/tens_o/ones_o : BCD result, valid after that edge
module bin_to_bcd (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start_i,
   input  logic [7:0] bin_i,
   output logic       done_c,
   output logic [3:0] hundreds_o,
   output logic [3:0] tens_o,
   output logic [3:0] ones_o
);

   logic [7:0]  bin_q, bin_d;
   logic [11:0] bcd_q, bcd_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        active_q, active_d;
   logic [11:0] adj;

   // Add-3 correction on each BCD nibble followed by a one-bit left shift.
   always_comb begin
      adj      = bcd_q;
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
      if (start_i) begin
         bin_d    = bin_i;
         bcd_d    = '0;
         cnt_d    = '0;
         active_d = 1'b1;
      end else if (active_q) begin
         bcd_d = {adj[10:0], bin_q[7]};
         bin_d = {bin_q[6:0], 1'b0};
         cnt_d = cnt_q + 3'd1;
         if (cnt_q == 3'd7) active_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else begin
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
      end
   end

   assign done_c     = active_q && (cnt_q == 3'd7);
   assign hundreds_o = bcd_q[11:8];
   assign tens_o     = bcd_q[7:4];
   assign ones_o     = bcd_q[3:0];

endmodule

// File: rtl/seg_display_driver.sv
`timescale 1ns/1ps
// 4-digit 7-segment driver: converts an 8-bit result to decimal (signed or
// unsigned) or hex and time-multiplexes the digits.
//  clock, reset_n : clock, async active-low reset
//  value, value_valid, signed_mode, hex_mode : load request and its modes
//  busy  : conversion in progress, loads dropped while high
//  shown : value committed to the display
//  seg   : active-low segments {g..a};  an : active-low anodes, an[0] rightmost
module seg_display_driver
   import seg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] value,
   input  logic       value_valid,
   input  logic       signed_mode,
   input  logic       hex_mode,
   output logic       busy,
   output logic [7:0] shown,
   output logic [6:0] seg,
   output logic [3:0] an
);

   localparam int unsigned        CNT_W   = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   state_e           state_q, state_d;
   logic [7:0]       val_q, val_d;
   logic             neg_q, neg_d;
   logic             hex_q, hex_d;
   logic [7:0]       shown_q, shown_d;
   digit_t           dig_q [4];
   digit_t           dig_d [4];
   logic [1:0]       idx_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic [3:0]       an_q;
   logic [6:0]       seg_q;

   logic             load_c;
   logic [7:0]       mag_c;
   logic             done_c;
   logic [3:0]       hun_c, ten_c, one_c;

   assign load_c = value_valid && (state_q == IDLE);
   assign mag_c  = (signed_mode && value[7]) ? (~value + 8'd1) : value;

   bin_to_bcd u_bcd (
      .clock      (clock),
      .reset_n    (reset_n),
      .start_i    (load_c && !hex_mode),
      .bin_i      (mag_c),
      .done_c     (done_c),
      .hundreds_o (hun_c),
      .tens_o     (ten_c),
      .ones_o     (one_c)
   );

   // Next-state, capture and commit logic.
   always_comb begin
      state_d = state_q;
      val_d   = val_q;
      neg_d   = neg_q;
      hex_d   = hex_q;
      shown_d = shown_q;
      dig_d   = dig_q;
      case (state_q)
         IDLE: begin
            if (load_c) begin
               val_d   = value;
               neg_d   = signed_mode && value[7];
               hex_d   = hex_mode;
               state_d = hex_mode ? COMMIT : CONVERT;
            end
         end
         CONVERT: begin
            if (done_c) state_d = COMMIT;
         end
         COMMIT: begin
            state_d = IDLE;
            shown_d = val_q;
            if (hex_q) begin
               dig_d[0] = make_digit(val_q[3:0], 1'b0);
               dig_d[1] = make_digit(val_q[7:4], 1'b0);
               dig_d[2] = DIGIT_BLANK;
               dig_d[3] = DIGIT_BLANK;
            end else begin
               // Leading-zero suppression; the sign stays pinned to the leftmost digit.
               dig_d[0] = make_digit(one_c, 1'b0);
               dig_d[1] = make_digit(ten_c, (hun_c == 4'd0) && (ten_c == 4'd0));
               dig_d[2] = make_digit(hun_c, hun_c == 4'd0);
               dig_d[3] = neg_q ? DIGIT_MINUS : DIGIT_BLANK;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         val_q   <= '0;
         neg_q   <= 1'b0;
         hex_q   <= 1'b0;
         shown_q <= '0;
         busy_q  <= 1'b0;
         dig_q[0] <= DIGIT_ZERO;
         for (int i = 1; i < 4; i++) dig_q[i] <= DIGIT_BLANK;
      end else begin
         state_q <= state_d;
         val_q   <= val_d;
         neg_q   <= neg_d;
         hex_q   <= hex_d;
         shown_q <= shown_d;
         busy_q  <= (state_d != IDLE);
         dig_q   <= dig_d;
      end
   end

   // Refresh counter, scan index and registered display outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         idx_q <= '0;
         an_q  <= 4'b1111;
         seg_q <= SEG_BLANK;
      end else begin
         if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
            idx_q <= idx_q + 2'd1;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         an_q  <= ~(4'b0001 << idx_q);
         seg_q <= digit_to_seg(dig_q[idx_q]);
      end
   end

   assign busy  = busy_q;
   assign shown = shown_q;
   assign an    = an_q;
   assign seg   = seg_q;

endmodule
